rvc_packer: RTL and testbench

Instruction-stream compressor and packer for the fetch path's producer side. It accepts 32-bit RV32I instructions on a valid/ready stream and rewrites each to its RVC 16-bit form when an exact equivalent exists. It packs the resulting mix of halfwords and words, little-endian, into aligned 32-bit output words. Its output is the mixed 16/32-bit stream that the fetch-side expander consumes.

---
 rtl/rvc_packer.sv | 178 +++++++++++++++++
 tb/tb_rvc_packer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rvc_packer.sv
// RV32I -> RVC compressor and little-endian halfword packer into aligned 32-bit words.
// Optional compressed-instruction counter on cmp_count when RVC_PACK_STATS_EN is defined.
module rvc_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word
`ifdef RVC_PACK_STATS_EN
    ,
    output logic [15:0] cmp_count
`endif
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm_i, imm_s;
    logic        rd_p, rs1_p, rs2_p, imm_small;
    logic        ca_ok;
    logic [1:0]  ca_fn;
    logic        is_c;
    logic [15:0] c_half;

    logic [15:0] hold;
    logic        hold_vld;
    logic        accept, flush_fire;

    assign opc   = in_instr[6:0];
    assign rd    = in_instr[11:7];
    assign f3    = in_instr[14:12];
    assign rs1   = in_instr[19:15];
    assign rs2   = in_instr[24:20];
    assign f7    = in_instr[31:25];
    assign imm_i = in_instr[31:20];
    assign imm_s = {in_instr[31:25], in_instr[11:7]};

    assign rd_p      = (rd[4:3] == 2'b01);
    assign rs1_p     = (rs1[4:3] == 2'b01);
    assign rs2_p     = (rs2[4:3] == 2'b01);
    // 6-bit signed immediate: upper bits must all be sign copies
    assign imm_small = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7f);

    always_comb begin
        ca_ok = 1'b0;
        ca_fn = 2'b00;
        if (f7 == 7'h20 && f3 == 3'b000) begin
            ca_ok = 1'b1;
            ca_fn = 2'b00;
        end else if (f7 == 7'h00) begin
            case (f3)
                3'b100: begin ca_ok = 1'b1; ca_fn = 2'b01; end
                3'b110: begin ca_ok = 1'b1; ca_fn = 2'b10; end
                3'b111: begin ca_ok = 1'b1; ca_fn = 2'b11; end
                default: ;
            endcase
        end
    end

    always_comb begin
        is_c   = 1'b0;
        c_half = 16'h0000;
        if (in_instr == 32'h0000_0013) begin
            is_c   = 1'b1;
            c_half = 16'h0001;
        end else if (opc == OPC_OP_IMM && f3 == 3'b000 && rs1 == 5'd0 && rd != 5'd0 && imm_small) begin
            is_c   = 1'b1;
            c_half = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (opc == OPC_OP_IMM && f3 == 3'b000 && rs1 == rd && rd != 5'd0 &&
                     imm_i != 12'd0 && imm_small) begin
            is_c   = 1'b1;
            c_half = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (opc == OPC_OP_IMM && f3 == 3'b001 && f7 == 7'h00 && rs1 == rd &&
                     rd != 5'd0 && rs2 != 5'd0) begin
            is_c   = 1'b1;
            c_half = {3'b000, 1'b0, rd, rs2, 2'b10};
        end else if (opc == OPC_OP && f7 == 7'h00 && f3 == 3'b000 && rd != 5'd0 &&
                     rs2 != 5'd0 && rs1 == 5'd0) begin
            is_c   = 1'b1;
            c_half = {4'b1000, rd, rs2, 2'b10};
        end else if (opc == OPC_OP && f7 == 7'h00 && f3 == 3'b000 && rd != 5'd0 &&
                     rs2 != 5'd0 && rs1 == rd) begin
            is_c   = 1'b1;
            c_half = {4'b1001, rd, rs2, 2'b10};
        end else if (opc == OPC_OP && ca_ok && rd_p && rs2_p && rs1 == rd) begin
            is_c   = 1'b1;
            c_half = {6'b100011, rd[2:0], ca_fn, rs2[2:0], 2'b01};
        end else if (opc == OPC_JALR && f3 == 3'b000 && imm_i == 12'd0 && rs1 != 5'd0 &&
                     rd == 5'd0) begin
            is_c   = 1'b1;
            c_half = {4'b1000, rs1, 5'd0, 2'b10};
        end else if (opc == OPC_JALR && f3 == 3'b000 && imm_i == 12'd0 && rs1 != 5'd0 &&
                     rd == 5'd1) begin
            is_c   = 1'b1;
            c_half = {4'b1001, rs1, 5'd0, 2'b10};
        end else if (opc == OPC_LOAD && f3 == 3'b010 && rd_p && rs1_p &&
                     imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'b00) begin
            is_c   = 1'b1;
            c_half = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
        end else if (opc == OPC_LOAD && f3 == 3'b010 && rd != 5'd0 && rs1 == 5'd2 &&
                     imm_i[11:8] == 4'd0 && imm_i[1:0] == 2'b00) begin
            is_c   = 1'b1;
            c_half = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
        end else if (opc == OPC_STORE && f3 == 3'b010 && rs2_p && rs1_p &&
                     imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'b00) begin
            is_c   = 1'b1;
            c_half = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
        end else if (opc == OPC_STORE && f3 == 3'b010 && rs1 == 5'd2 &&
                     imm_s[11:8] == 4'd0 && imm_s[1:0] == 2'b00) begin
            is_c   = 1'b1;
            c_half = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
        end else if (in_instr == 32'h0010_0073) begin
            is_c   = 1'b1;
            c_half = 16'h9002;
        end
    end

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    // an arriving instruction always wins; padding waits for an idle input cycle
    assign flush_fire = flush && !in_valid && in_ready && hold_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_word  <= 32'h0;
            hold      <= 16'h0;
            hold_vld  <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                if (!hold_vld) begin
                    if (is_c) begin
                        hold     <= c_half;
                        hold_vld <= 1'b1;
                    end else begin
                        out_word  <= in_instr;
                        out_valid <= 1'b1;
                    end
                end else if (is_c) begin
                    out_word  <= {c_half, hold};
                    out_valid <= 1'b1;
                    hold_vld  <= 1'b0;
                end else begin
                    out_word  <= {in_instr[15:0], hold};
                    hold      <= in_instr[31:16];
                    out_valid <= 1'b1;
                end
            end else if (flush_fire) begin
                out_word  <= {16'h0001, hold};
                out_valid <= 1'b1;
                hold_vld  <= 1'b0;
            end
        end
    end

`ifdef RVC_PACK_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cmp_count <= 16'h0;
        else if (accept && is_c)
            cmp_count <= cmp_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_rvc_packer.sv
// Directed bench for rvc_packer: compression table plus packing, backpressure, flush and reset sequences.
module tb_rvc_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
`ifdef RVC_PACK_STATS_EN
    logic [15:0] cmp_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rvc_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word)
`ifdef RVC_PACK_STATS_EN
        ,
        .cmp_count (cmp_count)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic        is_c;
        logic [15:0] half;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic expect_word(input string name, input logic [31:0] exp);
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_word"}, out_word, exp);
    endtask

    task automatic expect_none(input string name);
        chk({name, "_novalid"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic send(input logic [31:0] instr);
        in_valid = 1'b1;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{32'h0000_0013, 1'b1, 16'h0001};  // nop
        vecs[1]  = '{32'hFFF0_0293, 1'b1, 16'h52FD};  // li x5,-1
        vecs[2]  = '{32'h0014_0413, 1'b1, 16'h0405};  // addi x8,x8,1
        vecs[3]  = '{32'h0204_0413, 1'b0, 16'h0000};  // addi x8,x8,32 out of range
        vecs[4]  = '{32'h0004_0413, 1'b0, 16'h0000};  // addi x8,x8,0
        vecs[5]  = '{32'h00B5_0533, 1'b1, 16'h952E};  // add x10,x10,x11
        vecs[6]  = '{32'h00B0_0533, 1'b1, 16'h852E};  // mv x10,x11
        vecs[7]  = '{32'h0000_8067, 1'b1, 16'h8082};  // jr ra
        vecs[8]  = '{32'h0002_80E7, 1'b1, 16'h9282};  // jalr x5
        vecs[9]  = '{32'h0042_80E7, 1'b0, 16'h0000};  // jalr x1,4(x5)
        vecs[10] = '{32'h0044_2483, 1'b1, 16'h4044};  // lw x9,4(x8)
        vecs[11] = '{32'h0804_2483, 1'b0, 16'h0000};  // lw x9,128(x8)
        vecs[12] = '{32'h0694_2E23, 1'b1, 16'hDC64};  // sw x9,124(x8)
        vecs[13] = '{32'h0FC1_2083, 1'b1, 16'h50FE};  // lw x1,252(x2)
        vecs[14] = '{32'h0081_2003, 1'b0, 16'h0000};  // lw x0,8(x2)
        vecs[15] = '{32'h0011_2423, 1'b1, 16'hC406};  // sw x1,8(x2)
        vecs[16] = '{32'h0032_9293, 1'b1, 16'h028E};  // slli x5,x5,3
        vecs[17] = '{32'h0002_9293, 1'b0, 16'h0000};  // slli x5,x5,0
        vecs[18] = '{32'h4094_0433, 1'b1, 16'h8C05};  // sub x8,x8,x9
        vecs[19] = '{32'h0087_F7B3, 1'b1, 16'h8FE1};  // and x15,x15,x8
        vecs[20] = '{32'h0074_6433, 1'b0, 16'h0000};  // or x8,x8,x7 (rs2 not compressible)
        vecs[21] = '{32'h0010_0073, 1'b1, 16'h9002};  // ebreak
        vecs[22] = '{32'h0000_00EF, 1'b0, 16'h0000};  // jal x1,0

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_word", out_word, 32'h0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            send(vecs[i].instr);
            if (vecs[i].is_c) begin
                expect_none($sformatf("vec%0d_held", i));
                flush = 1'b1;
                tick();
                flush = 1'b0;
                expect_word($sformatf("vec%0d_c", i), {16'h0001, vecs[i].half});
            end else begin
                expect_word($sformatf("vec%0d_w", i), vecs[i].instr);
            end
            tick();
        end

        // compressed then word: word straddles, upper half stays held
        send(32'h0014_0413);
        expect_none("pack_a1");
        send(32'h0000_00EF);
        expect_word("pack_a2", 32'h00EF_0405);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_word("pack_a_flush", 32'h0001_0000);
        tick();
        expect_none("pack_a_drain");

        // backpressure: word pending, next instruction must stall
        out_ready = 1'b0;
        send(32'h0000_00EF);
        expect_word("bp_first", 32'h0000_00EF);
        in_valid = 1'b1;
        in_instr = 32'h0074_6433;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_in_ready%0d", k), {31'd0, in_ready}, 32'd0);
            expect_word($sformatf("bp_hold%0d", k), 32'h0000_00EF);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        expect_word("bp_resume", 32'h0074_6433);
        tick();
        expect_none("bp_drain");

        // flush together with in_valid: instruction first, padding later
        send(32'h0014_0413);
        in_valid = 1'b1;
        flush    = 1'b1;
        in_instr = 32'h0000_00EF;
        tick();
        in_valid = 1'b0;
        expect_word("fl_both", 32'h00EF_0405);
        tick();
        expect_word("fl_later", 32'h0001_0000);
        tick();
        flush = 1'b0;
        expect_none("fl_empty");

        // asynchronous reset with a held halfword and a pending word
        out_ready = 1'b0;
        send(32'h0014_0413);
        send(32'h0000_00EF);
        expect_word("rst2_pre", 32'h00EF_0405);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst2_out_word", out_word, 32'h0);
        chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef RVC_PACK_STATS_EN
        chk("rst2_cmp_count", {16'd0, cmp_count}, 32'd0);
`endif
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        expect_none("rst2_flush_nothing");

        // two compressed halfwords pack into one word
        send(32'h00B5_0533);
        expect_none("pack_b1");
        send(32'h0010_0073);
        expect_word("pack_b2", 32'h9002_952E);
`ifdef RVC_PACK_STATS_EN
        chk("stats_count", {16'd0, cmp_count}, 32'd2);
`endif
        tick();
        expect_none("pack_b_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
